// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray/binary helpers and default sizing shared by the read- and write-side FIFO blocks.
package fifo_pkg;

    localparam int ADDRSIZE_DEFAULT  = 5;
    localparam int AE_THRESH_DEFAULT = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_level_if.sv
// rptr_empty_level_if: read-side FIFO status bus between the pointer controller and its consumer.
interface rptr_empty_level_if import fifo_pkg::*; #(
    parameter int ADDRSIZE = ADDRSIZE_DEFAULT
);

    logic                rinc;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                raempty;
    logic [ADDRSIZE:0]   rlevel;
    logic                runderflow;

    modport master (
        output rinc, rq2_wptr,
        input  raddr, rptr, rempty, raempty, rlevel, runderflow
    );

    modport slave (
        input  rinc, rq2_wptr,
        output raddr, rptr, rempty, raempty, rlevel, runderflow
    );

endinterface

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary conversion; each bit is the XOR of all Gray bits at or above it.
module gray2bin_conv #(
    parameter int W = 6
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    genvar i;
    for (i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/rptr_empty_level.sv
// rptr_empty_level: read-side pointer, empty/almost-empty, fill level and sticky underflow for the async FIFO.
module rptr_empty_level import fifo_pkg::*; #(
    parameter int ADDRSIZE  = ADDRSIZE_DEFAULT,
    parameter int AE_THRESH = AE_THRESH_DEFAULT
) (
    input logic               rclk,
    input logic               rrst,
    rptr_empty_level_if.slave bus
);

    localparam int W = ADDRSIZE + 1;
    localparam logic [W-1:0] AE = W'(AE_THRESH);

    logic [W-1:0] rbin;
    logic [W-1:0] rbinnext;
    logic [W-1:0] rgraynext;
    logic [W-1:0] wbin;
    logic [W-1:0] diff;
    logic         rpop;

    assign rpop      = bus.rinc & ~bus.rempty;
    assign rbinnext  = rbin + W'(rpop);
    assign rgraynext = W'(bin2gray(32'(rbinnext)));
    // Wrap-around subtraction gives the occupancy even after either pointer rolls over.
    assign diff      = wbin - rbinnext;
    assign bus.raddr = rbin[ADDRSIZE-1:0];

    gray2bin_conv #(.W(W)) u_g2b (
        .gray (bus.rq2_wptr),
        .bin  (wbin)
    );

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin           <= '0;
            bus.rptr       <= '0;
            bus.rempty     <= 1'b1;
            bus.raempty    <= 1'b1;
            bus.rlevel     <= '0;
            bus.runderflow <= 1'b0;
        end else begin
            rbin        <= rbinnext;
            bus.rptr    <= rgraynext;
            bus.rempty  <= (rgraynext == bus.rq2_wptr);
            bus.raempty <= (diff <= AE);
            bus.rlevel  <= diff;
            if (bus.rinc && bus.rempty) bus.runderflow <= 1'b1;
        end
    end

endmodule
